// File: rtl/pipelined_control_unit.sv
// Pipelined control unit for a 5-stage RV32I core.
// Decodes the ID instruction, carries control through ID/EX, EX/MEM and MEM/WB,
// resolves branches and jumps in EX and raises the IF/ID flush request.
//
// Ports:
//   clk_i, rst_ni                     clock, async active-low reset
//   instr_valid_i, op_i, funct3_i,    ID instruction fields
//   funct7_i
//   stall_i                           hazard unit: bubble into ID/EX
//   zero_e_i, lt_e_i, ltu_e_i         EX comparison flags
//   imm_src_d_o, illegal_d_o          ID combinational decode outputs
//   alu_*_e_o, mem_read_e_o,          EX-stage control
//   pc_src_e_o, jalr_e_o, flush_o
//   mem_write_m_o, funct3_m_o         MEM-stage control
//   reg_write_w_o, result_src_w_o     WB-stage control
module pipelined_control_unit #(
    parameter int unsigned ALU_CTRL_W = 4,
    parameter int unsigned ENABLE_MUL = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  instr_valid_i,
    input  logic [6:0]            op_i,
    input  logic [2:0]            funct3_i,
    input  logic [6:0]            funct7_i,
    input  logic                  stall_i,
    input  logic                  zero_e_i,
    input  logic                  lt_e_i,
    input  logic                  ltu_e_i,
    output logic [2:0]            imm_src_d_o,
    output logic                  illegal_d_o,
    output logic [ALU_CTRL_W-1:0] alu_control_e_o,
    output logic                  alu_src_e_o,
    output logic [1:0]            alu_a_src_e_o,
    output logic                  mem_read_e_o,
    output logic                  pc_src_e_o,
    output logic                  jalr_e_o,
    output logic                  flush_o,
    output logic                  mem_write_m_o,
    output logic [2:0]            funct3_m_o,
    output logic                  reg_write_w_o,
    output logic [1:0]            result_src_w_o
);

    localparam logic [6:0] OpR     = 7'b0110011;
    localparam logic [6:0] OpImm   = 7'b0010011;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpBr    = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpJalr  = 7'b1100111;
    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpAuipc = 7'b0010111;

    localparam logic [3:0] AluAdd = 4'b0000;
    localparam logic [3:0] AluSub = 4'b0001;
    localparam logic [3:0] AluSra = 4'b1001;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [1:0] result_src;
        logic       alu_src;
        logic [1:0] a_src;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic [3:0] alu_ctrl;
        logic [2:0] funct3;
    } ex_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic [2:0] funct3;
    } mem_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
    } wb_ctrl_t;

    // funct3 -> ALU code for the funct7=0000000 encodings shared by R-type and I-arith.
    function automatic logic [3:0] base_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  base_alu = AluAdd;
            3'b001:  base_alu = 4'b0111;
            3'b010:  base_alu = 4'b0101;
            3'b011:  base_alu = 4'b0110;
            3'b100:  base_alu = 4'b0100;
            3'b101:  base_alu = 4'b1000;
            3'b110:  base_alu = 4'b0011;
            default: base_alu = 4'b0010;
        endcase
    endfunction

    ex_ctrl_t  dec;
    ex_ctrl_t  id_ex_d, id_ex_q;
    mem_ctrl_t ex_mem_q;
    wb_ctrl_t  mem_wb_q;
    logic      bad;
    logic      cond;

    always_comb begin
        dec         = '0;
        bad         = 1'b0;
        imm_src_d_o = 3'b000;
        case (op_i)
            OpR: begin
                dec.reg_write = 1'b1;
                if (funct7_i == 7'b0000000) begin
                    dec.alu_ctrl = base_alu(funct3_i);
                end else if (funct7_i == 7'b0100000) begin
                    if (funct3_i == 3'b000)      dec.alu_ctrl = AluSub;
                    else if (funct3_i == 3'b101) dec.alu_ctrl = AluSra;
                    else                         bad = 1'b1;
                end else if (ENABLE_MUL != 0 && funct7_i == 7'b0000001 && !funct3_i[2]) begin
                    dec.alu_ctrl = {2'b11, funct3_i[1:0]};
                end else begin
                    bad = 1'b1;
                end
            end
            OpImm: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                // Only shifts carry a funct7; other I-arith ops use those bits as immediate.
                if (funct3_i == 3'b001) begin
                    if (funct7_i == 7'b0000000) dec.alu_ctrl = base_alu(funct3_i);
                    else                        bad = 1'b1;
                end else if (funct3_i == 3'b101) begin
                    if (funct7_i == 7'b0000000)      dec.alu_ctrl = base_alu(funct3_i);
                    else if (funct7_i == 7'b0100000) dec.alu_ctrl = AluSra;
                    else                             bad = 1'b1;
                end else begin
                    dec.alu_ctrl = base_alu(funct3_i);
                end
            end
            OpLoad: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.mem_read   = 1'b1;
                dec.result_src = 2'b01;
            end
            OpStore: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                imm_src_d_o   = 3'b010;
            end
            OpBr: begin
                dec.branch   = 1'b1;
                dec.alu_ctrl = AluSub;
                imm_src_d_o  = 3'b001;
                if (funct3_i == 3'b010 || funct3_i == 3'b011) bad = 1'b1;
            end
            OpJal: begin
                dec.jump       = 1'b1;
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b10;
                imm_src_d_o    = 3'b100;
            end
            OpJalr: begin
                dec.jump       = 1'b1;
                dec.jalr       = 1'b1;
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b10;
                dec.alu_src    = 1'b1;
            end
            OpLui: begin
                dec.reg_write = 1'b1;
                dec.a_src     = 2'b10;
                dec.alu_src   = 1'b1;
                imm_src_d_o   = 3'b011;
            end
            OpAuipc: begin
                dec.reg_write = 1'b1;
                dec.a_src     = 2'b01;
                dec.alu_src   = 1'b1;
                imm_src_d_o   = 3'b011;
            end
            default: bad = 1'b1;
        endcase
        dec.valid   = 1'b1;
        dec.funct3  = funct3_i;
        illegal_d_o = instr_valid_i & bad;
        if (!instr_valid_i || bad) begin
            dec = '0;
        end
    end

    always_comb begin
        case (id_ex_q.funct3)
            3'b000:  cond = zero_e_i;
            3'b001:  cond = ~zero_e_i;
            3'b100:  cond = lt_e_i;
            3'b101:  cond = ~lt_e_i;
            3'b110:  cond = ltu_e_i;
            3'b111:  cond = ~ltu_e_i;
            default: cond = 1'b0;
        endcase
        pc_src_e_o = id_ex_q.valid & (id_ex_q.jump | (id_ex_q.branch & cond));
        flush_o    = pc_src_e_o;
        // Stall and flush both squash the ID instruction; the EX one always proceeds.
        id_ex_d    = (stall_i || pc_src_e_o) ? '0 : dec;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            id_ex_q  <= id_ex_d;
            ex_mem_q <= '{reg_write:  id_ex_q.reg_write,
                          result_src: id_ex_q.result_src,
                          mem_write:  id_ex_q.mem_write,
                          funct3:     id_ex_q.funct3};
            mem_wb_q <= '{reg_write:  ex_mem_q.reg_write,
                          result_src: ex_mem_q.result_src};
        end
    end

    assign alu_control_e_o = ALU_CTRL_W'(id_ex_q.alu_ctrl);
    assign alu_src_e_o     = id_ex_q.alu_src;
    assign alu_a_src_e_o   = id_ex_q.a_src;
    assign mem_read_e_o    = id_ex_q.mem_read;
    assign jalr_e_o        = id_ex_q.jalr;
    assign mem_write_m_o   = ex_mem_q.mem_write;
    assign funct3_m_o      = ex_mem_q.funct3;
    assign reg_write_w_o   = mem_wb_q.reg_write;
    assign result_src_w_o  = mem_wb_q.result_src;

endmodule

// File: tb/tb_pipelined_control_unit.sv
module tb_pipelined_control_unit;

    localparam logic [6:0] OpR     = 7'b0110011;
    localparam logic [6:0] OpImm   = 7'b0010011;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpBr    = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpJalr  = 7'b1100111;
    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpAuipc = 7'b0010111;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       instr_valid;
    logic [6:0] op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       stall;
    logic       zero_e, lt_e, ltu_e;

    logic [2:0] imm_src_d;
    logic       illegal_d;
    logic [3:0] alu_control_e;
    logic       alu_src_e;
    logic [1:0] alu_a_src_e;
    logic       mem_read_e, pc_src_e, jalr_e, flush;
    logic       mem_write_m;
    logic [2:0] funct3_m;
    logic       reg_write_w;
    logic [1:0] result_src_w;

    logic [2:0] m_imm_src_d;
    logic       m_illegal_d;
    logic [3:0] m_alu_control_e;
    logic       m_alu_src_e;
    logic [1:0] m_alu_a_src_e;
    logic       m_mem_read_e, m_pc_src_e, m_jalr_e, m_flush;
    logic       m_mem_write_m;
    logic [2:0] m_funct3_m;
    logic       m_reg_write_w;
    logic [1:0] m_result_src_w;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipelined_control_unit #(.ALU_CTRL_W(4), .ENABLE_MUL(0)) u_dut (
        .clk_i(clk), .rst_ni(rst_ni), .instr_valid_i(instr_valid), .op_i(op),
        .funct3_i(funct3), .funct7_i(funct7), .stall_i(stall), .zero_e_i(zero_e),
        .lt_e_i(lt_e), .ltu_e_i(ltu_e), .imm_src_d_o(imm_src_d), .illegal_d_o(illegal_d),
        .alu_control_e_o(alu_control_e), .alu_src_e_o(alu_src_e),
        .alu_a_src_e_o(alu_a_src_e), .mem_read_e_o(mem_read_e), .pc_src_e_o(pc_src_e),
        .jalr_e_o(jalr_e), .flush_o(flush), .mem_write_m_o(mem_write_m),
        .funct3_m_o(funct3_m), .reg_write_w_o(reg_write_w), .result_src_w_o(result_src_w)
    );

    pipelined_control_unit #(.ALU_CTRL_W(4), .ENABLE_MUL(1)) u_dut_mul (
        .clk_i(clk), .rst_ni(rst_ni), .instr_valid_i(instr_valid), .op_i(op),
        .funct3_i(funct3), .funct7_i(funct7), .stall_i(stall), .zero_e_i(zero_e),
        .lt_e_i(lt_e), .ltu_e_i(ltu_e), .imm_src_d_o(m_imm_src_d),
        .illegal_d_o(m_illegal_d), .alu_control_e_o(m_alu_control_e),
        .alu_src_e_o(m_alu_src_e), .alu_a_src_e_o(m_alu_a_src_e),
        .mem_read_e_o(m_mem_read_e), .pc_src_e_o(m_pc_src_e), .jalr_e_o(m_jalr_e),
        .flush_o(m_flush), .mem_write_m_o(m_mem_write_m), .funct3_m_o(m_funct3_m),
        .reg_write_w_o(m_reg_write_w), .result_src_w_o(m_result_src_w)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] o, input logic [2:0] f3,
                         input logic [6:0] f7);
        instr_valid = v;
        op          = o;
        funct3      = f3;
        funct7      = f7;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 7'd0, 3'd0, 7'd0);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        #1;
        n_tests++; if (reg_write_w !== 1'b0) begin n_fail++; $display("FAIL rst_reg_write: got %b want 0", reg_write_w); end
        n_tests++; if (pc_src_e !== 1'b0 || flush !== 1'b0) begin n_fail++; $display("FAIL rst_pc_src: got %b/%b want 0/0", pc_src_e, flush); end
        n_tests++; if (alu_control_e !== 4'd0) begin n_fail++; $display("FAIL rst_alu: got %b want 0000", alu_control_e); end
        @(negedge clk);
        rst_ni = 1'b1;
        step();
        // Store (SH) into MEM, then reset asynchronously while it sits there.
        drive(1'b1, OpStore, 3'b001, 7'd0);
        #1;
        n_tests++; if (imm_src_d !== 3'b010) begin n_fail++; $display("FAIL store_imm: got %b want 010", imm_src_d); end
        step();
        idle(1);
        n_tests++; if (mem_write_m !== 1'b1 || funct3_m !== 3'b001) begin n_fail++; $display("FAIL store_mem: got %b/%b want 1/001", mem_write_m, funct3_m); end
        rst_ni = 1'b0;
        #1;
        n_tests++; if (mem_write_m !== 1'b0) begin n_fail++; $display("FAIL async_rst_mem_write: got %b want 0", mem_write_m); end
        n_tests++; if (funct3_m !== 3'b000) begin n_fail++; $display("FAIL async_rst_funct3: got %b want 000", funct3_m); end
        @(negedge clk);
        rst_ni = 1'b1;
        step();
        n_tests++; if (mem_write_m !== 1'b0 || reg_write_w !== 1'b0) begin n_fail++; $display("FAIL post_rst: got %b/%b want 0/0", mem_write_m, reg_write_w); end
    endtask

    task automatic test_add_sub();
        drive(1'b1, OpR, 3'b000, 7'b0100000);
        #1;
        n_tests++; if (illegal_d !== 1'b0) begin n_fail++; $display("FAIL sub_legal: got %b want 0", illegal_d); end
        step();
        n_tests++; if (alu_control_e !== 4'b0001 || alu_src_e !== 1'b0) begin n_fail++; $display("FAIL sub_alu: got %b/%b want 0001/0", alu_control_e, alu_src_e); end
        drive(1'b1, OpImm, 3'b000, 7'b0100000);
        step();
        n_tests++; if (alu_control_e !== 4'b0000 || alu_src_e !== 1'b1) begin n_fail++; $display("FAIL addi_alu: got %b/%b want 0000/1", alu_control_e, alu_src_e); end
        n_tests++; if (reg_write_w !== 1'b0) begin n_fail++; $display("FAIL sub_early_wb: got %b want 0", reg_write_w); end
        idle(1);
        n_tests++; if (reg_write_w !== 1'b1 || result_src_w !== 2'b00) begin n_fail++; $display("FAIL sub_wb: got %b/%b want 1/00", reg_write_w, result_src_w); end
        step();
        n_tests++; if (reg_write_w !== 1'b1) begin n_fail++; $display("FAIL addi_wb: got %b want 1", reg_write_w); end
        step();
        n_tests++; if (reg_write_w !== 1'b0) begin n_fail++; $display("FAIL bubble_wb: got %b want 0", reg_write_w); end
        drive(1'b1, OpImm, 3'b101, 7'b0100000);
        step();
        n_tests++; if (alu_control_e !== 4'b1001) begin n_fail++; $display("FAIL srai_alu: got %b want 1001", alu_control_e); end
        drive(1'b1, OpR, 3'b101, 7'b0000000);
        step();
        n_tests++; if (alu_control_e !== 4'b1000) begin n_fail++; $display("FAIL srl_alu: got %b want 1000", alu_control_e); end
        idle(3);
    endtask

    task automatic test_branches();
        logic [2:0] br_f3 [6];
        logic [2:0] flags [3];
        logic [5:0] taken_tbl [3];
        logic       exp;
        br_f3     = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
        flags     = '{3'b100, 3'b010, 3'b001};
        // Bit i = taken for br_f3[i]; hand-derived from the condition table.
        taken_tbl = '{6'b101001, 6'b100110, 6'b011010};
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 6; i++) begin
                exp = taken_tbl[f][i];
                drive(1'b1, OpBr, br_f3[i], 7'd0);
                #1;
                n_tests++; if (imm_src_d !== 3'b001) begin n_fail++; $display("FAIL br_imm f3=%b: got %b want 001", br_f3[i], imm_src_d); end
                step();
                drive(1'b1, OpR, 3'b000, 7'd0);
                {zero_e, lt_e, ltu_e} = flags[f];
                #1;
                n_tests++; if (pc_src_e !== exp || flush !== exp) begin n_fail++; $display("FAIL br f3=%b flags=%b: got %b/%b want %b", br_f3[i], flags[f], pc_src_e, flush, exp); end
                step();
                {zero_e, lt_e, ltu_e} = 3'b000;
                idle(2);
                n_tests++; if (reg_write_w !== !exp) begin n_fail++; $display("FAIL br_shadow f3=%b flags=%b: got %b want %b", br_f3[i], flags[f], reg_write_w, !exp); end
            end
        end
        idle(2);
    endtask

    task automatic test_jumps();
        drive(1'b1, OpJal, 3'b000, 7'd0);
        #1;
        n_tests++; if (imm_src_d !== 3'b100) begin n_fail++; $display("FAIL jal_imm: got %b want 100", imm_src_d); end
        step();
        drive(1'b1, OpR, 3'b000, 7'd0);
        #1;
        n_tests++; if (pc_src_e !== 1'b1 || flush !== 1'b1 || jalr_e !== 1'b0) begin n_fail++; $display("FAIL jal_ex: got %b/%b/%b want 1/1/0", pc_src_e, flush, jalr_e); end
        step();
        idle(0);
        n_tests++; if (pc_src_e !== 1'b0) begin n_fail++; $display("FAIL jal_shadow_ex: got %b want 0", pc_src_e); end
        step();
        n_tests++; if (reg_write_w !== 1'b1 || result_src_w !== 2'b10) begin n_fail++; $display("FAIL jal_wb: got %b/%b want 1/10", reg_write_w, result_src_w); end
        step();
        n_tests++; if (reg_write_w !== 1'b0) begin n_fail++; $display("FAIL jal_squash: got %b want 0", reg_write_w); end
        drive(1'b1, OpJalr, 3'b000, 7'd0);
        #1;
        n_tests++; if (imm_src_d !== 3'b000) begin n_fail++; $display("FAIL jalr_imm: got %b want 000", imm_src_d); end
        step();
        n_tests++; if (jalr_e !== 1'b1 || pc_src_e !== 1'b1 || alu_src_e !== 1'b1) begin n_fail++; $display("FAIL jalr_ex: got %b/%b/%b want 1/1/1", jalr_e, pc_src_e, alu_src_e); end
        idle(2);
        n_tests++; if (reg_write_w !== 1'b1 || result_src_w !== 2'b10) begin n_fail++; $display("FAIL jalr_wb: got %b/%b want 1/10", reg_write_w, result_src_w); end
        idle(2);
    endtask

    task automatic test_load_use();
        drive(1'b1, OpLoad, 3'b010, 7'd0);
        step();
        n_tests++; if (mem_read_e !== 1'b1 || alu_src_e !== 1'b1) begin n_fail++; $display("FAIL lw_ex: got %b/%b want 1/1", mem_read_e, alu_src_e); end
        drive(1'b1, OpR, 3'b000, 7'd0);
        stall = 1'b1;
        step();
        stall = 1'b0;
        n_tests++; if (mem_read_e !== 1'b0) begin n_fail++; $display("FAIL stall_bubble: got %b want 0", mem_read_e); end
        n_tests++; if (funct3_m !== 3'b010 || mem_write_m !== 1'b0) begin n_fail++; $display("FAIL lw_mem: got %b/%b want 010/0", funct3_m, mem_write_m); end
        step();
        n_tests++; if (reg_write_w !== 1'b1 || result_src_w !== 2'b01) begin n_fail++; $display("FAIL lw_wb: got %b/%b want 1/01", reg_write_w, result_src_w); end
        n_tests++; if (mem_read_e !== 1'b0 || alu_src_e !== 1'b0) begin n_fail++; $display("FAIL add_after_stall: got %b/%b want 0/0", mem_read_e, alu_src_e); end
        idle(1);
        n_tests++; if (reg_write_w !== 1'b0) begin n_fail++; $display("FAIL stall_slot_wb: got %b want 0", reg_write_w); end
        step();
        n_tests++; if (reg_write_w !== 1'b1 || result_src_w !== 2'b00) begin n_fail++; $display("FAIL add_wb: got %b/%b want 1/00", reg_write_w, result_src_w); end
        idle(2);
    endtask

    task automatic test_upper();
        drive(1'b1, OpLui, 3'b000, 7'd0);
        #1;
        n_tests++; if (imm_src_d !== 3'b011) begin n_fail++; $display("FAIL lui_imm: got %b want 011", imm_src_d); end
        step();
        n_tests++; if (alu_a_src_e !== 2'b10 || alu_src_e !== 1'b1) begin n_fail++; $display("FAIL lui_ex: got %b/%b want 10/1", alu_a_src_e, alu_src_e); end
        drive(1'b1, OpAuipc, 3'b000, 7'd0);
        step();
        n_tests++; if (alu_a_src_e !== 2'b01 || alu_control_e !== 4'b0000) begin n_fail++; $display("FAIL auipc_ex: got %b/%b want 01/0000", alu_a_src_e, alu_control_e); end
        idle(3);
    endtask

    task automatic test_illegal_mul();
        drive(1'b1, OpR, 3'b011, 7'b0000001);
        #1;
        n_tests++; if (illegal_d !== 1'b1 || m_illegal_d !== 1'b0) begin n_fail++; $display("FAIL mulhu_illegal: got %b/%b want 1/0", illegal_d, m_illegal_d); end
        step();
        n_tests++; if (m_alu_control_e !== 4'b1111) begin n_fail++; $display("FAIL mulhu_alu: got %b want 1111", m_alu_control_e); end
        n_tests++; if (alu_control_e !== 4'b0000) begin n_fail++; $display("FAIL nomul_alu: got %b want 0000", alu_control_e); end
        idle(2);
        n_tests++; if (reg_write_w !== 1'b0 || m_reg_write_w !== 1'b1) begin n_fail++; $display("FAIL mul_wb: got %b/%b want 0/1", reg_write_w, m_reg_write_w); end
        drive(1'b1, OpBr, 3'b010, 7'd0);
        #1;
        n_tests++; if (illegal_d !== 1'b1) begin n_fail++; $display("FAIL br010_illegal: got %b want 1", illegal_d); end
        zero_e = 1'b1;
        step();
        n_tests++; if (pc_src_e !== 1'b0) begin n_fail++; $display("FAIL br010_bubble: got %b want 0", pc_src_e); end
        zero_e = 1'b0;
        drive(1'b1, OpImm, 3'b001, 7'b0100000);
        #1;
        n_tests++; if (illegal_d !== 1'b1) begin n_fail++; $display("FAIL slli_illegal: got %b want 1", illegal_d); end
        drive(1'b1, 7'b1111111, 3'b000, 7'd0);
        #1;
        n_tests++; if (illegal_d !== 1'b1) begin n_fail++; $display("FAIL op_illegal: got %b want 1", illegal_d); end
        drive(1'b1, OpR, 3'b000, 7'b0100000);
        #1;
        n_tests++; if (illegal_d !== 1'b0) begin n_fail++; $display("FAIL sub_not_illegal: got %b want 0", illegal_d); end
        drive(1'b1, OpR, 3'b100, 7'b0100000);
        #1;
        n_tests++; if (illegal_d !== 1'b1) begin n_fail++; $display("FAIL xor7_illegal: got %b want 1", illegal_d); end
        drive(1'b0, 7'b1111111, 3'b000, 7'd0);
        #1;
        n_tests++; if (illegal_d !== 1'b0) begin n_fail++; $display("FAIL invalid_not_illegal: got %b want 0", illegal_d); end
        idle(3);
    endtask

    initial begin
        rst_ni = 1'b0;
        stall  = 1'b0;
        zero_e = 1'b0;
        lt_e   = 1'b0;
        ltu_e  = 1'b0;
        drive(1'b0, 7'd0, 3'd0, 7'd0);
        test_reset();
        test_add_sub();
        test_branches();
        test_jumps();
        test_load_use();
        test_upper();
        test_illegal_mul();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
